branch_sequencer: RTL
=====================

Name: branch_sequencer

Overview:
- Owns the processor's flag register and program counter; it sits on both sides of the branch-condition path.
- Producer side: latches the ALU sign/carry/zero flags and drives them to the branch-condition logic.
- Consumer side: takes the resulting can_jump decision and updates the PC (sequential, branch, register branch, branch-and-link), issues flush bubbles and link-register writes.
- Sits between decode/ALU and instruction fetch.

Parameters:
- PC_WIDTH, 32, width of PC and all address ports
- RESET_PC, 0, PC value loaded on reset

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- instr_valid  in  1  decode presents a valid instruction this cycle
- opcode  in  6  opcode of the presented instruction
- branch_target  in  PC_WIDTH  absolute target for b/bl/conditional branches
- reg_target  in  PC_WIDTH  register-sourced target for br
- can_jump  in  1  branch decision for opcode, computed from this block's flag outputs
- stall  in  1  pipeline hold request
- flag_we  in  1  load ALU flags this cycle
- alu_sign  in  1  ALU result sign
- alu_carry  in  1  ALU carry out
- alu_zero  in  1  ALU result zero
- sign  out  1  registered sign flag
- carry  out  1  registered carry flag
- is_zero  out  1  registered zero flag
- pc  out  PC_WIDTH  current fetch address
- pc_valid  out  1  pc is a valid fetch request
- flush  out  1  one-cycle pulse: discard the instruction in decode
- link_we  out  1  one-cycle pulse: write link_data to the link register
- link_data  out  PC_WIDTH  return address (pc+4 of the bl)
- misaligned  out  1  sticky: a taken target had nonzero bits [1:0]

Behaviour:
- Reset (async, any time, including mid-flush): pc=RESET_PC, all flags 0, pc_valid=0, flush=0, link_we=0, link_data=0, misaligned=0, state=BOOT.
- Flags:
  - On a clk edge with flag_we=1, {sign,carry,is_zero} <= {alu_sign,alu_carry,alu_zero}. Otherwise they hold.
  - Flags are independent of stall and state.
  - A branch in the same cycle as flag_we is evaluated on the old, pre-edge flags; the new flags are visible one cycle later.
- Branch opcodes: 000111..001110. 001011 is br and uses reg_target; 001100 is bl; all others use branch_target.
- States:
  - BOOT: 1 cycle; pc_valid=0; instr_valid ignored; next state RUN with pc_valid=1.
  - RUN:
    - stall=1: pc holds; instruction not consumed; go to STALL.
    - else instr_valid=1, branch opcode, and can_jump=1 (taken):
      - pc <= {target[PC_WIDTH-1:2],2'b00}.
      - If target[1:0]!=0, set misaligned (sticky until reset).
      - flush=1 on the next cycle; go to FLUSH.
      - If bl: link_we=1 and link_data=pc+4 on the next cycle.
    - else instr_valid=1 (not taken, or non-branch): pc <= pc+4.
    - else instr_valid=0: pc holds.
  - STALL: pc and outputs hold; pc_valid stays 1; return to RUN on the first cycle with stall=0. The held instruction is then evaluated, including can_jump with the current flags.
  - FLUSH: exactly 1 cycle.
    - flush=1; instr_valid ignored; pc holds at the target.
    - Next state RUN, or STALL if stall=1.
- Stall takes priority over branch: no branch is taken, and no link is written, while stall=1.
- pc+4 wraps modulo 2^PC_WIDTH; no wrap indication.
- Outputs flush and link_we are registered; they are high only in the cycle after the taken branch.
- Non-taken branches (can_jump=0) behave exactly like sequential instructions. can_jump is ignored for non-branch opcodes.

Test Plan:
- Reset/boot: assert rst mid-run with pc=0x40 -> pc=0 immediately with no clk edge; after release, pc_valid=0 for 1 cycle, then pc=0, 4, 8 on successive instr_valid cycles.
- Taken conditional: pc=0x10, opcode=001000, can_jump=1, branch_target=0x80 -> next cycle pc=0x80 and flush=1 for exactly 1 cycle; instr_valid during FLUSH ignored; then pc=0x84.
- Not taken, plus flag timing: flag_we=1 with alu_zero=1 in the same cycle as opcode 001001 with can_jump=0 -> pc+4; is_zero=1 on the following cycle; flags hold while flag_we=0.
- bl and br: pc=0x20, opcode=001100, target=0x100, can_jump=1 -> pc=0x100, link_we=1, link_data=0x24. Then opcode=001011, reg_target=0x24 -> pc=0x24, link_we=0.
- Stall priority: stall=1 with a taken branch presented for 3 cycles -> pc held, flush=0, link_we=0. When stall=0, the branch is taken on that edge.
- Misaligned/wrap: taken target 0x102 -> pc=0x100 and misaligned=1, staying high until rst. Sequential from pc=0xFFFFFFFC -> pc=0x0.

Source files
------------

// File: rtl/branch_sequencer.sv
// Flag register plus PC sequencer: branch/br/bl redirect, one-cycle flush and link-write pulses.
// All outputs registered, one cycle after the deciding edge; i_stall freezes PC and blocks redirects.
module branch_sequencer #(
   parameter int                  PC_WIDTH = 32,
   parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
   input  logic                i_clk,
   input  logic                i_rst,
   input  logic                i_instr_valid,
   input  logic [5:0]          i_opcode,
   input  logic [PC_WIDTH-1:0] i_branch_target,
   input  logic [PC_WIDTH-1:0] i_reg_target,
   input  logic                i_can_jump,
   input  logic                i_stall,
   input  logic                i_flag_we,
   input  logic                i_alu_sign,
   input  logic                i_alu_carry,
   input  logic                i_alu_zero,
   output logic                o_sign,
   output logic                o_carry,
   output logic                o_is_zero,
   output logic [PC_WIDTH-1:0] o_pc,
   output logic                o_pc_valid,
   output logic                o_flush,
   output logic                o_link_we,
   output logic [PC_WIDTH-1:0] o_link_data,
   output logic                o_misaligned
);

   localparam logic [5:0]          OP_BRANCH_FIRST = 6'b000111;
   localparam logic [5:0]          OP_BRANCH_LAST  = 6'b001110;
   localparam logic [5:0]          OP_BR           = 6'b001011;
   localparam logic [5:0]          OP_BL           = 6'b001100;
   localparam logic [PC_WIDTH-1:0] PC_STEP         = PC_WIDTH'(4);

   typedef enum logic [1:0] {
      ST_BOOT,
      ST_RUN,
      ST_STALL,
      ST_FLUSH
   } state_t;

   state_t                r_state;
   logic [PC_WIDTH-1:0]   r_pc;
   logic                  r_pc_valid;
   logic                  r_flush;
   logic                  r_link_we;
   logic [PC_WIDTH-1:0]   r_link_data;
   logic                  r_misaligned;
   logic                  r_sign;
   logic                  r_carry;
   logic                  r_zero;

   logic                  w_is_branch;
   logic                  w_is_br;
   logic                  w_is_bl;
   logic                  w_taken;
   logic [PC_WIDTH-1:0]   w_target;
   logic [PC_WIDTH-1:0]   w_pc_seq;

   always_comb begin
      w_is_branch = (i_opcode >= OP_BRANCH_FIRST) && (i_opcode <= OP_BRANCH_LAST);
      w_is_br     = (i_opcode == OP_BR);
      w_is_bl     = (i_opcode == OP_BL);
      w_target    = w_is_br ? i_reg_target : i_branch_target;
      w_taken     = i_instr_valid && w_is_branch && i_can_jump;
      w_pc_seq    = r_pc + PC_STEP;
   end

   // Flags are written regardless of state or stall; a branch on the same edge sees the old values.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_sign  <= 1'b0;
         r_carry <= 1'b0;
         r_zero  <= 1'b0;
      end else if (i_flag_we) begin
         r_sign  <= i_alu_sign;
         r_carry <= i_alu_carry;
         r_zero  <= i_alu_zero;
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state      <= ST_BOOT;
         r_pc         <= RESET_PC;
         r_pc_valid   <= 1'b0;
         r_flush      <= 1'b0;
         r_link_we    <= 1'b0;
         r_link_data  <= '0;
         r_misaligned <= 1'b0;
      end else begin
         r_flush   <= 1'b0;
         r_link_we <= 1'b0;
         case (r_state)
            ST_BOOT: begin
               r_pc_valid <= 1'b1;
               r_state    <= ST_RUN;
            end
            // STALL re-evaluates the held instruction as soon as the stall drops.
            ST_RUN, ST_STALL: begin
               if (i_stall) begin
                  r_state <= ST_STALL;
               end else if (w_taken) begin
                  r_pc    <= {w_target[PC_WIDTH-1:2], 2'b00};
                  r_flush <= 1'b1;
                  r_state <= ST_FLUSH;
                  if (|w_target[1:0]) begin
                     r_misaligned <= 1'b1;
                  end
                  if (w_is_bl) begin
                     r_link_we   <= 1'b1;
                     r_link_data <= w_pc_seq;
                  end
               end else begin
                  if (i_instr_valid) begin
                     r_pc <= w_pc_seq;
                  end
                  r_state <= ST_RUN;
               end
            end
            ST_FLUSH: begin
               r_state <= i_stall ? ST_STALL : ST_RUN;
            end
            default: begin
               r_state <= ST_BOOT;
            end
         endcase
      end
   end

   assign o_sign       = r_sign;
   assign o_carry      = r_carry;
   assign o_is_zero    = r_zero;
   assign o_pc         = r_pc;
   assign o_pc_valid   = r_pc_valid;
   assign o_flush      = r_flush;
   assign o_link_we    = r_link_we;
   assign o_link_data  = r_link_data;
   assign o_misaligned = r_misaligned;

endmodule
